// File: rtl/rob_tag_allocator_if.sv
// Tag allocator bus: AR-side grant, R-side lookup/release and pool status.
// The master modport is the ROB datapath; the slave modport is the allocator.
interface rob_tag_allocator_if #(
  parameter int ID_WIDTH        = 4,
  parameter int TAG_WIDTH       = 4,
  parameter int MAX_OUTSTANDING = 16
);
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  logic                 alloc_valid;
  logic [ID_WIDTH-1:0]  alloc_orig_id;
  logic                 alloc_ready;
  logic [TAG_WIDTH-1:0] alloc_tag;

  logic [TAG_WIDTH-1:0] lookup_tag;
  logic [ID_WIDTH-1:0]  lookup_orig_id;
  logic                 lookup_hit;

  logic                 release_valid;
  logic [TAG_WIDTH-1:0] release_tag;

  logic [CNT_WIDTH-1:0] busy_count;
  logic                 all_free;
  logic                 err_bad_release;

  modport master (
    output alloc_valid, alloc_orig_id, lookup_tag, release_valid, release_tag,
    input  alloc_ready, alloc_tag, lookup_orig_id, lookup_hit,
           busy_count, all_free, err_bad_release
  );

  modport slave (
    input  alloc_valid, alloc_orig_id, lookup_tag, release_valid, release_tag,
    output alloc_ready, alloc_tag, lookup_orig_id, lookup_hit,
           busy_count, all_free, err_bad_release
  );
endinterface

// File: rtl/rob_tag_allocator.sv
// ROB tag pool: FIFO free list of UIDs plus a per-tag table of original ARIDs.
// Grant is same-cycle from registered state; a released tag is grantable next cycle.
module rob_tag_allocator #(
  parameter int ID_WIDTH        = 4,
  parameter int TAG_WIDTH       = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input logic                clk,
  input logic                rst,
  rob_tag_allocator_if.slave tag_if
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PW-1:0]        LAST_PTR  = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0]        POOL_SIZE = CW'(MAX_OUTSTANDING);
  localparam logic [TAG_WIDTH:0]   TAG_LIMIT = (TAG_WIDTH + 1)'(MAX_OUTSTANDING);

  logic [TAG_WIDTH-1:0] free_list_q [MAX_OUTSTANDING];
  logic [TAG_WIDTH-1:0] free_list_d [MAX_OUTSTANDING];
  logic [ID_WIDTH-1:0]  orig_id_q   [MAX_OUTSTANDING];
  logic [ID_WIDTH-1:0]  orig_id_d   [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] in_use_q, in_use_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] free_count_q, free_count_d;
  logic [CW-1:0] busy_count_q, busy_count_d;
  logic          err_q, err_d;

  logic [TAG_WIDTH-1:0] head_tag;
  logic [PW-1:0]        alloc_idx;
  logic [PW-1:0]        rel_idx;
  logic [PW-1:0]        look_idx;
  logic                 alloc_fire;
  logic                 rel_in_range;
  logic                 rel_ok;
  logic                 look_in_range;
  logic                 look_hit;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Every tag is < MAX_OUTSTANDING <= 2**PW, so the low PW bits index the table.
  assign head_tag      = free_list_q[rd_ptr_q];
  assign alloc_idx     = head_tag[PW-1:0];
  assign rel_idx       = tag_if.release_tag[PW-1:0];
  assign look_idx      = tag_if.lookup_tag[PW-1:0];

  assign alloc_fire    = tag_if.alloc_valid && (free_count_q != '0);
  assign rel_in_range  = {1'b0, tag_if.release_tag} < TAG_LIMIT;
  assign rel_ok        = tag_if.release_valid && rel_in_range && in_use_q[rel_idx];
  assign look_in_range = {1'b0, tag_if.lookup_tag} < TAG_LIMIT;
  assign look_hit      = look_in_range && in_use_q[look_idx];

  always_comb begin
    free_list_d  = free_list_q;
    orig_id_d    = orig_id_q;
    in_use_d     = in_use_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    err_d        = err_q;

    if (alloc_fire) begin
      rd_ptr_d             = next_ptr(rd_ptr_q);
      in_use_d[alloc_idx]  = 1'b1;
      orig_id_d[alloc_idx] = tag_if.alloc_orig_id;
    end

    // A same-cycle release can never target the head tag: it is not yet in use.
    if (rel_ok) begin
      free_list_d[wr_ptr_q] = tag_if.release_tag;
      wr_ptr_d              = next_ptr(wr_ptr_q);
      in_use_d[rel_idx]     = 1'b0;
    end

    if (tag_if.release_valid && !rel_ok) begin
      err_d = 1'b1;
    end

    free_count_d = free_count_q - CW'(alloc_fire) + CW'(rel_ok);
    busy_count_d = POOL_SIZE - free_count_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        free_list_q[i] <= TAG_WIDTH'(i);
        orig_id_q[i]   <= '0;
      end
      in_use_q     <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      free_count_q <= POOL_SIZE;
      busy_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      free_list_q  <= free_list_d;
      orig_id_q    <= orig_id_d;
      in_use_q     <= in_use_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      free_count_q <= free_count_d;
      busy_count_q <= busy_count_d;
      err_q        <= err_d;
    end
  end

  assign tag_if.alloc_ready     = (free_count_q != '0);
  assign tag_if.alloc_tag       = head_tag;
  assign tag_if.lookup_hit      = look_hit;
  assign tag_if.lookup_orig_id  = look_hit ? orig_id_q[look_idx] : '0;
  assign tag_if.busy_count      = busy_count_q;
  assign tag_if.all_free        = (free_count_q == POOL_SIZE);
  assign tag_if.err_bad_release = err_q;

  // Pool accounting: free entries plus tags in use always cover the whole pool.
  a_pool_conserved: assert property (@(posedge clk) disable iff (rst)
    (int'(free_count_q) + $countones(in_use_q)) == MAX_OUTSTANDING);

endmodule
